calc_req_issuer: RTL
====================

CALC_REQ_ISSUER -- requirements
Module: calc_req_issuer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of queued operations (power of two, >=2).
REQ-002 Parameter TIMEOUT_CYCLES, default 64, response-wait limit in clock cycles.
REQ-003 a_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 op_valid  input  1  upstream operation offered.
REQ-006 op_ready  output  1  operation accepted this cycle if op_valid also high.
REQ-007 op_cmd  input  [0:3]  calculator command.
REQ-008 op_data1, op_data2  input  [0:31] each  operands 1 and 2.
REQ-009 req_cmd_out  output  [0:3]  drives one calculator port's reqN_cmd_in.
REQ-010 req_data_out  output  [0:31]  drives that port's reqN_data_in.
REQ-011 out_resp  input  [0:1]  calculator response code for the port.
REQ-012 out_data  input  [0:31]  calculator result for the port.
REQ-013 res_valid  output  1  one-cycle result strobe.
REQ-014 res_cmd, res_resp, res_data  output  [0:3], [0:1], [0:31]  echoed command, response code, result.
REQ-015 busy  output  1  high when FSM not IDLE or FIFO non-empty.
REQ-016 timeout_err  output  1  one-cycle pulse on response timeout.

Function
REQ-017 The FIFO shall push on op_valid && op_ready; op_ready = !full, combinational from FIFO state only.
REQ-018 Simultaneous push and pop on a non-empty, non-full FIFO shall both take effect; pointers wrap modulo FIFO_DEPTH.
REQ-019 The FSM shall have states IDLE, SEND1, SEND2, WAIT.
REQ-020 IDLE: FIFO non-empty -> pop the head and enter SEND1; otherwise stay.
REQ-021 SEND1: req_cmd_out = cmd, req_data_out = data1; next SEND2.
REQ-022 SEND2: req_cmd_out = 0, req_data_out = data2; next WAIT.
REQ-023 WAIT, and IDLE: req_cmd_out = 0, req_data_out = 0.
REQ-024 All port outputs shall be registered: an op pushed into an empty idle block at edge k appears on the pins from edge k+1 (SEND1), k+2 (SEND2), k+3 (zeros).
REQ-025 WAIT with out_resp != 0 -> capture cmd/out_resp/out_data, assert res_valid for exactly one cycle from the next edge, return to IDLE.
REQ-026 A response in the same cycle the FIFO is non-empty shall still produce the strobe; the next pop occurs in IDLE one cycle later.
REQ-027 out_resp != 0 outside WAIT shall be ignored.
REQ-028 Only one operation shall be outstanding at the calculator port at any time.

Reset
REQ-029 reset shall force IDLE and empty the FIFO, discarding queued and in-flight ops.
REQ-030 Reset values: req_cmd_out 0, req_data_out 0, res_valid 0, res_cmd 0, res_resp 0, res_data 0, busy 0, timeout_err 0; op_ready 1 from the first cycle after reset.
REQ-031 Reset asserted mid-WAIT shall suppress any later res_valid for that op.

Configuration
REQ-032 Macro CALC_REQ_TIMEOUT_EN defined: a WAIT counter clears on entry; on reaching TIMEOUT_CYCLES without a response, pulse timeout_err and res_valid with res_resp = 0, res_data = 0, res_cmd = cmd, then go to IDLE.
REQ-033 Macro undefined: no counter; WAIT persists until a response; timeout_err tied 0.

Structure
REQ-034 Shared package calc_pkg shall hold command codes (0 nop, 1 add, 2 sub, 5 shl, 6 shr), response codes (0 none, 1 ok, 2 overflow/underflow, 3 invalid), width constants and the FSM state enum.
REQ-035 Sub-module calc_req_fifo shall implement the operation FIFO (cmd+data1+data2 entries, full/empty flags).

Verification
REQ-036 Push add 1,4; calculator answers resp 1 data 5 in WAIT -> pins show cmd 1/data 1, then 0/4, then zeros; res_valid one cycle with res_cmd 1, res_resp 1, res_data 5.
REQ-037 Push 5 ops with no pops in progress (FIFO_DEPTH 4, FSM held in WAIT) -> op_ready low after 4th accepted; 5th held until a slot frees.
REQ-038 With CALC_REQ_TIMEOUT_EN, no response for 64 cycles -> timeout_err and res_valid same cycle, res_resp 0, FSM IDLE.
REQ-039 Reset asserted 3 cycles into WAIT with 2 ops queued -> outputs zero, busy 0, no res_valid after a later out_resp pulse.
REQ-040 Two queued ops, first responds resp 3 -> res_resp 3 strobe, second SEND1 begins two edges after the response edge.
REQ-041 out_resp = 1 driven during SEND1 -> ignored; no res_valid until response in WAIT.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg -- shared definitions for the calculator request issuer.
//   Command codes, response codes, datapath widths, the issuer FSM state
//   encoding and the packed operation record stored in the operation FIFO.
package calc_pkg;

   localparam int CMD_W  = 4;
   localparam int DATA_W = 32;
   localparam int RESP_W = 2;

   localparam logic [0:CMD_W-1] CMD_NOP = 4'd0;
   localparam logic [0:CMD_W-1] CMD_ADD = 4'd1;
   localparam logic [0:CMD_W-1] CMD_SUB = 4'd2;
   localparam logic [0:CMD_W-1] CMD_SHL = 4'd5;
   localparam logic [0:CMD_W-1] CMD_SHR = 4'd6;

   localparam logic [0:RESP_W-1] RESP_NONE = 2'd0;
   localparam logic [0:RESP_W-1] RESP_OK   = 2'd1;
   localparam logic [0:RESP_W-1] RESP_OVF  = 2'd2;
   localparam logic [0:RESP_W-1] RESP_INV  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND1 = 2'd1,
      ST_SEND2 = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   typedef struct packed {
      logic [0:CMD_W-1]  cmd;
      logic [0:DATA_W-1] data1;
      logic [0:DATA_W-1] data2;
   } op_t;

endpackage

// File: rtl/calc_req_fifo.sv
// calc_req_fifo -- operation queue in front of the request issuer.
//   clk, reset         : clock, synchronous active-high reset (empties queue)
//   push, wr_*         : enqueue request and entry (ignored when full)
//   pop, rd_*          : dequeue request and head entry (head valid when !empty)
//   full, empty        : occupancy flags, derived from registered state only
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module calc_req_fifo
   import calc_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [0:CMD_W-1]  wr_cmd,
   input  logic [0:DATA_W-1] wr_data1,
   input  logic [0:DATA_W-1] wr_data2,
   input  logic              pop,
   output logic [0:CMD_W-1]  rd_cmd,
   output logic [0:DATA_W-1] rd_data1,
   output logic [0:DATA_W-1] rd_data2,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   op_t              mem_q [DEPTH];
   logic             push_en, pop_en;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;

   assign rd_cmd   = mem_q[rd_ptr_q].cmd;
   assign rd_data1 = mem_q[rd_ptr_q].data1;
   assign rd_data2 = mem_q[rd_ptr_q].data2;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; stale entries are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_q[wr_ptr_q] <= '{cmd: wr_cmd, data1: wr_data1, data2: wr_data2};
      end
   end

endmodule

// File: rtl/calc_req_issuer.sv
// calc_req_issuer -- queues calculator operations and issues them one at a
// time on a single calculator port, returning each result as a strobe.
//   a_clk, reset             : clock, synchronous active-high reset
//   op_valid/op_ready/op_*   : upstream operation handshake (cmd, data1, data2)
//   req_cmd_out/req_data_out : registered drive of the calculator port
//   out_resp/out_data        : calculator response code and result
//   res_valid/res_*          : one-cycle result strobe with echoed command
//   busy                     : FSM active or operations queued
//   timeout_err              : one-cycle pulse when a response never arrived
// Optional feature: define CALC_REQ_TIMEOUT_EN to bound the response wait to
// TIMEOUT_CYCLES; otherwise WAIT persists until a response and timeout_err is 0.
module calc_req_issuer
   import calc_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        a_clk,
   input  logic        reset,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [0:3]  op_cmd,
   input  logic [0:31] op_data1,
   input  logic [0:31] op_data2,
   output logic [0:3]  req_cmd_out,
   output logic [0:31] req_data_out,
   input  logic [0:1]  out_resp,
   input  logic [0:31] out_data,
   output logic        res_valid,
   output logic [0:3]  res_cmd,
   output logic [0:1]  res_resp,
   output logic [0:31] res_data,
   output logic        busy,
   output logic        timeout_err
);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("calc_req_issuer: FIFO_DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("calc_req_issuer: TIMEOUT_CYCLES must be >= 1");
   end

   state_t            state_q, state_d;
   logic [0:CMD_W-1]  cur_cmd_q, cur_cmd_d;
   logic [0:DATA_W-1] cur_data2_q, cur_data2_d;
   logic [0:CMD_W-1]  req_cmd_q, req_cmd_d;
   logic [0:DATA_W-1] req_data_q, req_data_d;
   logic              res_valid_q, res_valid_d;
   logic [0:CMD_W-1]  res_cmd_q, res_cmd_d;
   logic [0:RESP_W-1] res_resp_q, res_resp_d;
   logic [0:DATA_W-1] res_data_q, res_data_d;

   logic              fifo_full, fifo_empty, fifo_pop, fifo_push;
   logic [0:CMD_W-1]  head_cmd;
   logic [0:DATA_W-1] head_data1, head_data2;

`ifdef CALC_REQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
`endif

   assign op_ready  = !fifo_full;
   assign fifo_push = op_valid && !fifo_full;

   calc_req_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (a_clk),
      .reset    (reset),
      .push     (fifo_push),
      .wr_cmd   (op_cmd),
      .wr_data1 (op_data1),
      .wr_data2 (op_data2),
      .pop      (fifo_pop),
      .rd_cmd   (head_cmd),
      .rd_data1 (head_data1),
      .rd_data2 (head_data2),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // Port drive is computed for the state being entered, so the registered
   // pins line up with the state the FSM is in after the edge.
   always_comb begin
      state_d     = state_q;
      cur_cmd_d   = cur_cmd_q;
      cur_data2_d = cur_data2_q;
      fifo_pop    = 1'b0;
      req_cmd_d   = CMD_NOP;
      req_data_d  = '0;
      res_valid_d = 1'b0;
      res_cmd_d   = res_cmd_q;
      res_resp_d  = res_resp_q;
      res_data_d  = res_data_q;
`ifdef CALC_REQ_TIMEOUT_EN
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               cur_cmd_d   = head_cmd;
               cur_data2_d = head_data2;
               req_cmd_d   = head_cmd;
               req_data_d  = head_data1;
               state_d     = ST_SEND1;
            end
         end
         ST_SEND1: begin
            req_data_d = cur_data2_q;
            state_d    = ST_SEND2;
         end
         ST_SEND2: begin
`ifdef CALC_REQ_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (out_resp != RESP_NONE) begin
               res_valid_d = 1'b1;
               res_cmd_d   = cur_cmd_q;
               res_resp_d  = out_resp;
               res_data_d  = out_data;
               state_d     = ST_IDLE;
`ifdef CALC_REQ_TIMEOUT_EN
            end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // Report the abandoned op with an empty response.
               timeout_d   = 1'b1;
               res_valid_d = 1'b1;
               res_cmd_d   = cur_cmd_q;
               res_resp_d  = RESP_NONE;
               res_data_d  = '0;
               state_d     = ST_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge a_clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         req_cmd_q   <= '0;
         req_data_q  <= '0;
         res_valid_q <= 1'b0;
         res_cmd_q   <= '0;
         res_resp_q  <= '0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         req_cmd_q   <= req_cmd_d;
         req_data_q  <= req_data_d;
         res_valid_q <= res_valid_d;
         res_cmd_q   <= res_cmd_d;
         res_resp_q  <= res_resp_d;
         res_data_q  <= res_data_d;
      end
   end

   // In-flight operation fields; only read after being loaded from the FIFO.
   always_ff @(posedge a_clk) begin
      cur_cmd_q   <= cur_cmd_d;
      cur_data2_q <= cur_data2_d;
   end

`ifdef CALC_REQ_TIMEOUT_EN
   always_ff @(posedge a_clk) begin
      if (reset) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end
   assign timeout_err = timeout_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign req_cmd_out  = req_cmd_q;
   assign req_data_out = req_data_q;
   assign res_valid    = res_valid_q;
   assign res_cmd      = res_cmd_q;
   assign res_resp     = res_resp_q;
   assign res_data     = res_data_q;
   assign busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule
